// File: rtl/cs_pkg.sv
// cs_pkg: shared helpers for the CS window filter.
//   clog2()       - ceiling log2, usable in constant expressions
//   calc_sw()     - running-sum width  DW + clog2(N)
//   calc_ow()     - output width       DW + clog2(2N) - SHIFT
//   round_const() - half-LSB constant added before the final shift when rounding
package cs_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int calc_sw(input int dw, input int n);
        return dw + clog2(n);
    endfunction

    function automatic int calc_ow(input int dw, input int n, input int shift);
        return dw + clog2(2 * n) - shift;
    endfunction

    function automatic int round_const(input int shift);
        return (shift > 0) ? (1 << (shift - 1)) : 0;
    endfunction

endpackage

// File: rtl/cs_approx_sel.sv
// cs_approx_sel: purely combinational Xappr selector.
// Returns the largest window entry x with x*N <= sum, i.e. the largest sample
// not exceeding the window average, without using a divider.
// Ports:
//   win_i   [N][DW]  window contents (after the current accept)
//   sum_i   [SW]     running sum of the window
//   xappr_o [DW]     selected sample
module cs_approx_sel
    import cs_pkg::*;
#(
    parameter int DW = 8,
    parameter int N  = 9
) (
    input  logic [N-1:0][DW-1:0]       win_i,
    input  logic [calc_sw(DW,N)-1:0]   sum_i,
    output logic [DW-1:0]              xappr_o
);

    localparam int SW = calc_sw(DW, N);
    localparam logic [SW-1:0] N_S = SW'(N);

    // x*N always fits in SW bits because N <= 2^clog2(N).
    logic [SW-1:0] prod;
    logic [DW-1:0] best;

    // Max reduction over the entries that pass the multiply-compare.
    // The minimum entry always passes, so the result is always defined.
    always_comb begin
        best = '0;
        prod = '0;
        for (int i = 0; i < N; i++) begin
            prod = N_S * SW'(win_i[i]);
            if ((prod <= sum_i) && (win_i[i] > best)) begin
                best = win_i[i];
            end
        end
    end

    assign xappr_o = best;

endmodule

// File: rtl/cs_window_filter.sv
// cs_window_filter: sliding-window CS approximation filter.
// Keeps the last N samples in a circular buffer with a running sum, selects
// Xappr (largest sample <= window average) and outputs
//   Y = (sum + N*Xappr) >> SHIFT
// one cycle after each accept that leaves the window full.
// Optional build macro CS_ROUND_EN: round half-up before the shift and
// saturate Y at 2^OW-1; otherwise truncate. Port list is identical.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low
//   in_valid   X is accepted this cycle
//   X   [DW]   input sample, unsigned
//   out_valid  single-cycle pulse per result
//   Y   [OW]   filtered result, held between results
// Handshake: there is no ready; every cycle with in_valid==1 accepts X, and
// out_valid pulses the following cycle iff that accept left the window full.
module cs_window_filter
    import cs_pkg::*;
#(
    parameter int DW    = 8,
    parameter int N     = 9,
    parameter int SHIFT = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [DW-1:0]                    X,
    output logic                             out_valid,
    output logic [calc_ow(DW,N,SHIFT)-1:0]   Y
);

    localparam int SW = calc_sw(DW, N);
    localparam int OW = calc_ow(DW, N, SHIFT);
    localparam int PW = clog2(N);
    localparam int FW = clog2(N + 1);
    localparam logic [SW:0] N_A = (SW+1)'(N);

    logic [N-1:0][DW-1:0] buf_q, buf_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic [SW-1:0]        sum_q, sum_d;
    logic                 out_valid_q;
    logic [OW-1:0]        y_q, y_d;

    logic [DW-1:0]        oldest;
    logic                 full_now;
    logic [DW-1:0]        xappr;
    logic [SW:0]          acc;

    // Unfilled slots were cleared at reset, so oldest reads 0 while filling.
    assign oldest   = buf_q[ptr_q];
    assign sum_d    = sum_q + SW'(X) - SW'(oldest);
    assign full_now = (fill_q >= FW'(N - 1));
    assign ptr_d    = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + 1'b1;
    assign fill_d   = (fill_q == FW'(N)) ? fill_q : fill_q + 1'b1;

    always_comb begin
        buf_d        = buf_q;
        buf_d[ptr_q] = X;
    end

    cs_approx_sel #(
        .DW (DW),
        .N  (N)
    ) u_sel (
        .win_i   (buf_d),
        .sum_i   (sum_d),
        .xappr_o (xappr)
    );

    // sum + N*Xappr <= 2*sum_max, which needs exactly SW+1 bits.
    assign acc = {1'b0, sum_d} + N_A * (SW+1)'(xappr);

`ifdef CS_ROUND_EN
    localparam logic [SW+1:0] RND = (SW+2)'(round_const(SHIFT));
    logic [SW+1:0] acc_r;
    logic [OW:0]   sh_r;

    always_comb begin
        acc_r = {1'b0, acc} + RND;
        sh_r  = (OW+1)'(acc_r >> SHIFT);
        y_d   = sh_r[OW] ? '1 : sh_r[OW-1:0];
    end
`else
    // SW+1-SHIFT == OW, so this truncation drops only zero bits.
    always_comb begin
        y_d = OW'(acc >> SHIFT);
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_q       <= '0;
            ptr_q       <= '0;
            fill_q      <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else begin
            out_valid_q <= in_valid && full_now;
            if (in_valid) begin
                buf_q  <= buf_d;
                ptr_q  <= ptr_d;
                fill_q <= fill_d;
                sum_q  <= sum_d;
                if (full_now) begin
                    y_q <= y_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Y         = y_q;

endmodule

// File: tb/tb_cs_window_filter.sv
module tb_cs_window_filter;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] X;
  logic       out_valid;
  logic [9:0] Y;

  int checks = 0;
  int errors = 0;

  // hand-computed expectations (default DW=8, N=9, SHIFT=3)
`ifdef CS_ROUND_EN
  localparam logic [9:0] E_S1  = 10'h017;  // (180+4)>>3
  localparam logic [9:0] E_S2  = 10'h00B;  // (90+4)>>3
  localparam logic [9:0] E_S2B = 10'h00E;  // (108+4)>>3
  localparam logic [9:0] E_FFN = 10'h23E;  // (4590+4)>>3
`else
  localparam logic [9:0] E_S1  = 10'h016;  // 180>>3
  localparam logic [9:0] E_S2  = 10'h00B;  // 90>>3
  localparam logic [9:0] E_S2B = 10'h00D;  // 108>>3
  localparam logic [9:0] E_FFN = 10'h23D;  // 4590>>3
`endif
  localparam logic [9:0] E_S3  = 10'h00B;  // sum 90, Xappr 0
  localparam logic [9:0] E_FF1 = 10'd43;   // sum 345, Xappr 0
  localparam logic [9:0] E_GAP = 10'h0FF;  // sum 2040, Xappr 0
  localparam logic [9:0] E_S5  = 10'h02D;  // sum 180, Xappr 20

  cs_window_filter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .X         (X),
    .out_valid (out_valid),
    .Y         (Y)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change #1 after the edge, outputs sampled there too
  task automatic accept(input logic [7:0] x);
    in_valid = 1'b1;
    X        = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset low 2 cycles
    reset    = 1'b0;
    in_valid = 1'b0;
    X        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_y", 16'(Y), 16'd0);
    reset = 1'b1;

    // scenario 1: nine 0x0A samples
    for (int i = 0; i < 8; i++) begin
      accept(8'h0A);
      chk("s1_fill_valid", 16'(out_valid), 16'd0);
    end
    accept(8'h0A);
    chk("s1_valid", 16'(out_valid), 16'd1);
    chk("s1_y", 16'(Y), 16'(E_S1));

    // scenario 2: 1..9 then 10, window already full so results every cycle
    for (int v = 1; v <= 8; v++) begin
      accept(8'(v));
      chk("s2_stream_valid", 16'(out_valid), 16'd1);
    end
    accept(8'd9);
    chk("s2_y_1to9", 16'(Y), 16'(E_S2));
    accept(8'd10);
    chk("s2_y_2to10", 16'(Y), 16'(E_S2B));

    // scenario 3: eight zeros then 0x5A, then nine 0xFF
    for (int i = 0; i < 8; i++) accept(8'h00);
    accept(8'h5A);
    chk("s3_valid", 16'(out_valid), 16'd1);
    chk("s3_y_avg10", 16'(Y), 16'(E_S3));
    accept(8'hFF);
    chk("s3_y_first_ff", 16'(Y), 16'(E_FF1));
    for (int i = 0; i < 7; i++) accept(8'hFF);
    accept(8'hFF);
    chk("s3_y_all_ff", 16'(Y), 16'(E_FFN));

    // gap: in_valid low 5 cycles, Y held, then one more accept
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("gap_valid", 16'(out_valid), 16'd0);
      chk("gap_y_hold", 16'(Y), 16'(E_FFN));
    end
    accept(8'h00);
    chk("gap_after_valid", 16'(out_valid), 16'd1);
    chk("gap_after_y", 16'(Y), 16'(E_GAP));

    // mid-operation reset after six accepts of a second window
    for (int i = 0; i < 6; i++) accept(8'h14);
    reset = 1'b0;
    idle();
    chk("rst2_valid", 16'(out_valid), 16'd0);
    chk("rst2_y", 16'(Y), 16'd0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      accept(8'h14);
      chk("rst2_refill_valid", 16'(out_valid), 16'd0);
    end
    accept(8'h14);
    chk("rst2_valid_9th", 16'(out_valid), 16'd1);
    chk("rst2_y_9th", 16'(Y), 16'(E_S5));
    idle();
    chk("rst2_pulse_end", 16'(out_valid), 16'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
